// File: rtl/ann_ctrl_pkg.sv
// Shared definitions for the neuron-layer MAC sequencer.
//   state_e     : sequencer states (IDLE, CLEAR, RUN, DRAIN, LOAD, VALID)
//   MEM_RD_LAT  : read latency of the weight/input memories, in cycles
//   idx_w()     : index width for a count of n items (never below 1 bit)
package ann_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_LOAD  = 3'd4,
    S_VALID = 3'd5
  } state_e;

  localparam int MEM_RD_LAT = 1;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/idx_counter.sv
// Wrapping index counter used for both the input and the neuron index.
//   clk, rst : clock, synchronous active-high reset
//   clr      : force index to 0 (wins over inc)
//   inc      : advance index, wrapping MAX-1 -> 0
//   idx      : current index
//   last     : idx == MAX-1
module idx_counter #(
  parameter int MAX = 8,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] idx,
  output logic         last
);

  logic [W-1:0] idx_q, idx_d;

  assign last = (idx_q == W'(MAX - 1));
  assign idx  = idx_q;

  always_comb begin
    idx_d = idx_q;
    if (clr)      idx_d = '0;
    else if (inc) idx_d = last ? '0 : idx_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) idx_q <= '0;
    else     idx_q <= idx_d;
  end

endmodule

// File: rtl/neuron_mac_ctrl.sv
// Sequencer for one neuron-layer MAC datapath. One start walks every neuron:
// clear accumulator, read N_INPUTS weight/input pairs, drain the last product,
// load the output register, then hold the result on a valid/ready handshake.
//   clk, rst   : clock, synchronous active-high reset
//   start      : begin a layer (IDLE only); abort: return to IDLE
//   busy       : not IDLE
//   mem_rd     : memory read strobe, in_idx is the read address
//   nr_idx     : neuron currently being computed / presented
//   acc_clr    : clear accumulator; acc_en: accumulate the memory product
//   out_en     : load output register
//   out_valid  : result for nr_idx available; out_ready: downstream accepts
//   done       : one-cycle pulse after the last neuron's handshake
module neuron_mac_ctrl
  import ann_ctrl_pkg::*;
#(
  parameter int N_INPUTS  = 8,
  parameter int N_NEURONS = 4,
  parameter int IN_W      = idx_w(N_INPUTS),
  parameter int NR_W      = idx_w(N_NEURONS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  output logic            busy,
  output logic            mem_rd,
  output logic [IN_W-1:0] in_idx,
  output logic [NR_W-1:0] nr_idx,
  output logic            acc_clr,
  output logic            acc_en,
  output logic            out_en,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            done
);

  state_e                state_q, state_d;
  logic [MEM_RD_LAT-1:0] acc_pipe_q, acc_pipe_d;
  logic                  done_q, done_d;
  logic                  hs, in_last, nr_last;
  logic                  in_clr, in_inc, nr_clr, nr_inc;

  // Handshake is still reported as taken under abort, but abort owns the
  // next state and suppresses done.
  assign hs = (state_q == S_VALID) && out_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_CLEAR;
      S_CLEAR: state_d = S_RUN;
      S_RUN:   if (in_last) state_d = S_DRAIN;
      S_DRAIN: state_d = S_LOAD;
      S_LOAD:  state_d = S_VALID;
      S_VALID: if (out_ready) state_d = nr_last ? S_IDLE : S_CLEAR;
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;

    // in_idx is zero on every CLEAR entry and whenever we sit in IDLE.
    in_clr = (state_d == S_CLEAR) || (state_d == S_IDLE);
    in_inc = (state_q == S_RUN) && !abort;
    nr_clr = abort;
    nr_inc = hs && !abort;   // wraps to 0 on the last neuron
    done_d = hs && nr_last && !abort;

    // acc_en trails mem_rd by the memory read latency; abort flushes any
    // read still in flight so no stray accumulate follows.
    acc_pipe_d = abort ? '0
                       : ((acc_pipe_q << 1) | MEM_RD_LAT'(state_q == S_RUN));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      acc_pipe_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_pipe_q <= acc_pipe_d;
      done_q     <= done_d;
    end
  end

  idx_counter #(.MAX(N_INPUTS), .W(IN_W)) u_in_cnt (
    .clk (clk), .rst (rst), .clr (in_clr), .inc (in_inc),
    .idx (in_idx), .last (in_last)
  );

  idx_counter #(.MAX(N_NEURONS), .W(NR_W)) u_nr_cnt (
    .clk (clk), .rst (rst), .clr (nr_clr), .inc (nr_inc),
    .idx (nr_idx), .last (nr_last)
  );

  assign busy      = (state_q != S_IDLE);
  assign mem_rd    = (state_q == S_RUN);
  assign acc_clr   = (state_q == S_CLEAR);
  assign out_en    = (state_q == S_LOAD);
  assign out_valid = (state_q == S_VALID);
  assign acc_en    = acc_pipe_q[MEM_RD_LAT-1];
  assign done      = done_q;

endmodule
